bios_port_arbiter: RTL

Arbitrates the single read port of the BIOS block memory between the instruction-fetch stage and the data-side load path. Both requesters target the BIOS region, where address bits [31:28] == 4'b0100. The block issues at most one memory read per cycle and returns each result one cycle later to the requester that owns it. Data loads take priority, and a bounded-run rule prevents fetch from starving. It sits between the IF/MEM pipeline stages and the BIOS memory port, beside the fetch-source decode.

---
 rtl/bios_port_arbiter_if.sv | 41 ++++
 rtl/bios_port_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bios_port_arbiter_if.sv
// rtl/bios_port_arbiter_if.sv - request, grant, response and memory-port bundle of the BIOS read arbiter
//
// Purpose: groups the fetch request, data-load request, per-requester grant and
// response signals, and the BIOS memory read port into one bundle.
// Port summary:
//   fetch  : if_req, if_pc[31:0], stall -> if_gnt, if_stall, if_rvalid, if_rdata[31:0]
//   data   : d_req, d_addr[31:0]        -> d_gnt, d_rvalid, d_rdata[31:0]
//   memory : mem_en, mem_addr[ADDR_W-1:0] out; mem_rdata[31:0] in (one cycle after mem_en)
// Modports: slave = arbiter side, master = requester/memory side.

interface bios_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              if_req;
    logic [31:0]       if_pc;
    logic              stall;
    logic              d_req;
    logic [31:0]       d_addr;
    logic              if_gnt;
    logic              d_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              if_stall;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_pc, stall, d_req, d_addr, mem_rdata,
        output if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
               if_stall, mem_en, mem_addr
    );

    modport master (
        output if_req, if_pc, stall, d_req, d_addr, mem_rdata,
        input  if_gnt, d_gnt, if_rvalid, if_rdata, d_rvalid, d_rdata,
               if_stall, mem_en, mem_addr
    );
endinterface

// File: rtl/bios_port_arbiter.sv
// rtl/bios_port_arbiter.sv - single-port BIOS read arbiter between instruction fetch and data loads
//
// Purpose: issues at most one BIOS read per cycle, giving data loads priority
// while bounding how many consecutive data grants a waiting fetch can suffer.
// Read data returns one cycle after the grant to the requester that owns it.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : bios_port_arbiter_if.slave (requests, grants, responses, memory port)
// Parameters:
//   ADDR_W       : BIOS word-address width (mem_addr = byte_addr[ADDR_W+1:2])
//   MAX_DATA_RUN : max consecutive data grants while fetch is waiting (>= 1)

module bios_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bios_port_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

    typedef enum logic {
        DATA_FIRST  = 1'b0,
        FETCH_FIRST = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic [1:0]        tag_q, tag_d;       // bit 0: fetch owns the in-flight read, bit 1: data
    logic [31:0]       if_hold_q, if_hold_d;
    logic [31:0]       d_hold_q, d_hold_d;

    logic fq, dq;
    logic if_gnt_c, d_gnt_c;

    // Requests outside the BIOS region, or a stalled fetch, are invisible here.
    assign fq = bus.if_req & ~bus.stall & (bus.if_pc[31:28] == 4'b0100);
    assign dq = bus.d_req & (bus.d_addr[31:28] == 4'b0100);

    always_comb begin
        if_gnt_c  = 1'b0;
        d_gnt_c   = 1'b0;
        state_d   = state_q;
        run_cnt_d = run_cnt_q;

        unique case (state_q)
            DATA_FIRST: begin
                d_gnt_c  = dq;
                if_gnt_c = fq & ~dq;
            end
            FETCH_FIRST: begin
                if_gnt_c = fq;
                d_gnt_c  = dq & ~fq;
            end
            default: ;
        endcase

        // A grant shown during reset must not start a read or leave an owner tag.
        if (reset) begin
            if_gnt_c = 1'b0;
            d_gnt_c  = 1'b0;
        end

        unique case (state_q)
            DATA_FIRST: begin
                if (!fq || if_gnt_c) begin
                    run_cnt_d = '0;
                end else if (d_gnt_c) begin
                    // Saturating: the count never wraps past the run limit.
                    if (run_cnt_q != RUN_MAX) begin
                        run_cnt_d = run_cnt_q + CNT_W'(1);
                    end
                    if (run_cnt_d == RUN_MAX) begin
                        state_d = FETCH_FIRST;
                    end
                end
            end
            FETCH_FIRST: begin
                // Any fetch grant or fetch withdrawal ends the fetch-priority window.
                if (!fq || if_gnt_c) begin
                    state_d   = DATA_FIRST;
                    run_cnt_d = '0;
                end
            end
            default: ;
        endcase

        tag_d     = {d_gnt_c, if_gnt_c};
        if_hold_d = tag_q[0] ? bus.mem_rdata : if_hold_q;
        d_hold_d  = tag_q[1] ? bus.mem_rdata : d_hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DATA_FIRST;
            run_cnt_q <= '0;
            tag_q     <= '0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            tag_q     <= tag_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

    assign bus.if_gnt   = if_gnt_c;
    assign bus.d_gnt    = d_gnt_c;
    assign bus.mem_en   = if_gnt_c | d_gnt_c;
    assign bus.mem_addr = if_gnt_c ? bus.if_pc[ADDR_W+1:2] :
                          d_gnt_c  ? bus.d_addr[ADDR_W+1:2] : '0;
    assign bus.if_stall = fq & ~if_gnt_c;

    // In the rvalid cycle the data passes straight through; otherwise the hold register.
    assign bus.if_rvalid = tag_q[0];
    assign bus.d_rvalid  = tag_q[1];
    assign bus.if_rdata  = if_hold_d;
    assign bus.d_rdata   = d_hold_d;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.if_pc[27:ADDR_W+2], bus.if_pc[1:0],
                                bus.d_addr[27:ADDR_W+2], bus.d_addr[1:0]};
endmodule
